// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit unsigned subtractor (A - B): one 1-bit subtract cell, LSB first, start/busy/done handshake.
// Optional build macro SERIAL_SUB_SATURATE_EN: clamp D to zero whenever the final borrow is set.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Br
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Single-bit subtract stage, returns {borrow_out, difference}
    function automatic logic [1:0] sub_cell(input logic a, input logic b, input logic bin);
        logic diff;
        logic bout;
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
        return {bout, diff};
    endfunction

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sha;
    logic [WIDTH-1:0] r_shb;
    logic [WIDTH-1:0] r_res;
    logic             r_bor;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_d;
    logic             r_br;

    logic [1:0]       w_cell;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_d_final;
    logic             w_last;

    // Current bit-cell result and the value D would take on the final RUN edge
    always_comb begin
        w_cell     = sub_cell(r_sha[0], r_shb[0], r_bor);
        w_res_next = {w_cell[0], r_res[WIDTH-1:1]};
        w_last     = (r_cnt == CW'(WIDTH - 1));
`ifdef SERIAL_SUB_SATURATE_EN
        if (w_cell[1]) begin
            w_d_final = {WIDTH{1'b0}};
        end else begin
            w_d_final = w_res_next;
        end
`else
        w_d_final = w_res_next;
`endif
    end

    // Sequencer: operand capture, per-bit shift, completion load and done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sha   <= {WIDTH{1'b0}};
            r_shb   <= {WIDTH{1'b0}};
            r_res   <= {WIDTH{1'b0}};
            r_bor   <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_d     <= {WIDTH{1'b0}};
            r_br    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sha   <= A;
                        r_shb   <= B;
                        r_res   <= {WIDTH{1'b0}};
                        r_bor   <= 1'b0;
                        r_cnt   <= {CW{1'b0}};
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sha <= {1'b0, r_sha[WIDTH-1:1]};
                    r_shb <= {1'b0, r_shb[WIDTH-1:1]};
                    r_res <= w_res_next;
                    r_bor <= w_cell[1];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_d     <= w_d_final;
                        r_br    <= w_cell[1];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign D    = r_d;
    assign Br   = r_br;

endmodule
